int_ctrl: RTL and testbench
===========================

# int_ctrl

Memory-mapped interrupt controller placed between the device IRQ lines (timers and future peripherals) and the CPU `HWInt[7:2]` input. It latches rising edges from up to `N_SRC` sources, masks them, and picks one winner by fixed or round-robin priority. It presents the winner to the CPU as a one-hot line and holds it in service until software ends it with an end-of-interrupt (EOI) write. It hangs off the bridge as an ordinary device using the timer-style register interface.

## Interface
- `N_SRC`, default 6: number of interrupt sources, which is also the `IRQ_O` width; legal range 2..8.
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `ADD_I` input 4: byte address from the bridge; `ADD_I[3:2]` selects the word, `ADD_I[1:0]` is ignored.
- `WE_I` input 1: write strobe, one cycle per write.
- `DAT_I` input 32: write data.
- `DAT_O` output 32: read data, combinational from `ADD_I` and registers; reads have no side effects.
- `IRQ_I` input `N_SRC`: raw device requests; assumed registered at the source.
- `IRQ_O` output `N_SRC`: one-hot request to the CPU, wired directly to `HWInt`; zero or one bit high.

## Operation
- Register map (word offsets):
  - 0x0 CTRL (RW): [0] GEN, global enable; [1] RR, 1 = round-robin, 0 = fixed priority with source 0 highest.
  - 0x4 MASK (RW): [N_SRC-1:0] per-source enable.
  - 0x8 PEND (R / write-1-to-clear): [N_SRC-1:0] latched edges.
  - 0xC CLAIM: read returns {[31] in-service, [30] asserting, [2:0] GRANT_ID}, other bits 0. Any write acts as claim (in ASSERT) or EOI (in SERVICE).
- Unused register bits read 0; writes to them are dropped.
- Edge capture:
  - `irq_q` is a registered copy of `IRQ_I`.
  - PEND[i] sets when `IRQ_I[i] & ~irq_q[i]`.
  - When a set and a W1C clear hit the same bit in the same cycle, the set wins.
- Eligible set E = PEND & MASK, and is empty when GEN = 0.
- Arbiter picks the winner from E:
  - Fixed mode: lowest index wins.
  - RR mode: first set bit at or after `rr_ptr`, wrapping from N_SRC-1 to 0.
- FSM states: IDLE, ASSERT, SERVICE.
  - IDLE → ASSERT: when E is non-empty; GRANT_ID latches the winner.
  - ASSERT, held: GRANT_ID is frozen; a higher-priority arrival does not preempt.
  - ASSERT → SERVICE: on a CLAIM write; PEND[GRANT_ID] clears.
  - ASSERT → IDLE: when E[GRANT_ID] drops (MASK bit cleared, PEND bit W1C'd, or GEN cleared). GRANT_ID is kept for readback.
  - SERVICE → IDLE: on a CLAIM write (EOI). `rr_ptr` becomes (GRANT_ID+1) mod N_SRC.
  - SERVICE ignores GEN/MASK/PEND changes; only EOI or reset exits.
  - CLAIM writes in IDLE are ignored.
- `IRQ_O` is registered; it equals onehot(GRANT_ID) while in ASSERT and is 0 otherwise.
- Reset state: CTRL, MASK, PEND, `irq_q`, GRANT_ID, `rr_ptr` all 0; FSM in IDLE; `IRQ_O` = 0.
- Reset asserted mid-operation drops `IRQ_O` immediately (asynchronous) and loses all pending state.

## Timing
- Source `IRQ_I` rises before edge k:
  - PEND set at edge k.
  - ASSERT entered and `IRQ_O` high after edge k+1, i.e. 2-cycle latency.
- CLAIM write sampled at edge m: `IRQ_O` low after edge m.
- EOI at edge m with E non-empty: IDLE for one cycle, ASSERT again after edge m+1. Minimum gap between assertions is one cycle.
- A source that stays high produces exactly one PEND event; it must fall and rise again to re-request.
- Register writes take effect at the sampling edge. Arbitration in the same edge uses the pre-write values.

## Structure
- Shared header/package `int_ctrl_defs`:
  - Register offsets: `IC_CTRL`, `IC_MASK`, `IC_PEND`, `IC_CLAIM`.
  - FSM state encodings.
  - CTRL bit positions.
- Sub-module `int_ctrl_arb`: purely combinational picker.
  - Inputs: E, `rr_ptr`, RR.
  - Outputs: valid, winner id.
  - Parameterised by N_SRC.
- The top holds the registers, edge capture, FSM and bus decode.

## Test plan
- Reset, write MASK=0x3F and CTRL=1, pulse `IRQ_I[2]` → PEND=0x04 next edge; `IRQ_O`=0x04 one edge later; CLAIM reads 0x4000_0002.
- Fixed mode, `IRQ_I[1]` and `IRQ_I[4]` rise together → grant 1. After claim + EOI, grant 4 follows after one idle cycle.
- RR mode, sources 0 and 1 re-pulsed after each EOI → grants alternate 0,1,0,1. Fixed mode with the same stimulus → always 0.
- While in ASSERT on source 3, write MASK=0x37 → `IRQ_O` goes to 0 next edge, FSM in IDLE, PEND[3] still 1.
- W1C to PEND[5] in the same cycle as an `IRQ_I[5]` rising edge → PEND[5] stays 1. `IRQ_I[5]` held high for 10 cycles → a single grant.
- Assert `reset` while in SERVICE → `IRQ_O`=0 asynchronously; all registers read 0 after release.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register offsets, FSM
// state encoding and CTRL bit positions.
package int_ctrl_defs;

    localparam logic [3:0] IC_CTRL  = 4'h0;
    localparam logic [3:0] IC_MASK  = 4'h4;
    localparam logic [3:0] IC_PEND  = 4'h8;
    localparam logic [3:0] IC_CLAIM = 4'hC;

    localparam int CTRL_GEN = 0;
    localparam int CTRL_RR  = 1;

    typedef enum logic [1:0] {
        IC_IDLE    = 2'd0,
        IC_ASSERT  = 2'd1,
        IC_SERVICE = 2'd2
    } ic_state_e;

endpackage

// File: rtl/int_ctrl_arb.sv
// Combinational winner picker: lowest eligible index in fixed mode, first
// eligible index at or after rr_ptr (wrapping) in round-robin mode.
module int_ctrl_arb #(
    parameter int N_SRC = 6
) (
    input  logic [N_SRC-1:0] elig,
    input  logic [2:0]       rr_ptr,
    input  logic             rr,
    output logic             valid,
    output logic [2:0]       id
);

    always_comb begin
        int j;
        valid = 1'b0;
        id    = '0;
        j     = 0;
        for (int k = 0; k < N_SRC; k++) begin
            j = rr ? int'(rr_ptr) + k : k;
            if (j >= N_SRC) j = j - N_SRC;
            if (!valid && elig[j]) begin
                valid = 1'b1;
                id    = 3'(j);
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Memory-mapped interrupt controller: edge capture, masking, arbitration and
// an IDLE/ASSERT/SERVICE handshake with software via the CLAIM register.
module int_ctrl
    import int_ctrl_defs::*;
#(
    parameter int N_SRC = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       ADD_I,
    input  logic             WE_I,
    input  logic [31:0]      DAT_I,
    output logic [31:0]      DAT_O,
    input  logic [N_SRC-1:0] IRQ_I,
    output logic [N_SRC-1:0] IRQ_O
);

    logic             gen, rr;
    logic [N_SRC-1:0] mask, pend, irq_q, elig, rise, pend_clr;
    logic [2:0]       grant_id, rr_ptr, win_id;
    logic             win_vld;
    logic             wr_ctrl, wr_mask, wr_pend, wr_claim;
    ic_state_e        state;
    logic [3:0]       word_addr;
    logic             unused_bits;

    function automatic logic [N_SRC-1:0] onehot(input logic [2:0] idx);
        logic [N_SRC-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign word_addr   = {ADD_I[3:2], 2'b00};
    assign wr_ctrl     = WE_I && (word_addr == IC_CTRL);
    assign wr_mask     = WE_I && (word_addr == IC_MASK);
    assign wr_pend     = WE_I && (word_addr == IC_PEND);
    assign wr_claim    = WE_I && (word_addr == IC_CLAIM);
    assign unused_bits = ^{ADD_I[1:0], DAT_I[31:N_SRC]};

    assign elig = gen ? (pend & mask) : '0;
    assign rise = IRQ_I & ~irq_q;

    int_ctrl_arb #(.N_SRC(N_SRC)) u_arb (
        .elig   (elig),
        .rr_ptr (rr_ptr),
        .rr     (rr),
        .valid  (win_vld),
        .id     (win_id)
    );

    // Clears come from W1C and from a claim; a new edge in the same cycle wins.
    always_comb begin
        pend_clr = '0;
        if (wr_pend) pend_clr = DAT_I[N_SRC-1:0];
        if (wr_claim && state == IC_ASSERT) pend_clr[grant_id] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gen   <= 1'b0;
            rr    <= 1'b0;
            mask  <= '0;
            pend  <= '0;
            irq_q <= '0;
        end else begin
            irq_q <= IRQ_I;
            pend  <= (pend & ~pend_clr) | rise;
            if (wr_ctrl) begin
                gen <= DAT_I[CTRL_GEN];
                rr  <= DAT_I[CTRL_RR];
            end
            if (wr_mask) mask <= DAT_I[N_SRC-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IC_IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
            IRQ_O    <= '0;
        end else begin
            case (state)
                IC_IDLE: begin
                    if (win_vld) begin
                        state    <= IC_ASSERT;
                        grant_id <= win_id;
                        IRQ_O    <= onehot(win_id);
                    end
                end
                IC_ASSERT: begin
                    if (wr_claim) begin
                        state <= IC_SERVICE;
                        IRQ_O <= '0;
                    end else if (!elig[grant_id]) begin
                        state <= IC_IDLE;
                        IRQ_O <= '0;
                    end
                end
                IC_SERVICE: begin
                    if (wr_claim) begin
                        state  <= IC_IDLE;
                        rr_ptr <= (grant_id == 3'(N_SRC - 1)) ? 3'd0 : grant_id + 3'd1;
                    end
                end
                default: begin
                    state <= IC_IDLE;
                    IRQ_O <= '0;
                end
            endcase
        end
    end

    always_comb begin
        DAT_O = '0;
        case (word_addr)
            IC_CTRL:  DAT_O = {30'd0, rr, gen};
            IC_MASK:  DAT_O = {{(32 - N_SRC){1'b0}}, mask};
            IC_PEND:  DAT_O = {{(32 - N_SRC){1'b0}}, pend};
            IC_CLAIM: DAT_O = {state == IC_SERVICE, state == IC_ASSERT, 27'd0, grant_id};
            default:  DAT_O = '0;
        endcase
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed scenarios with literal expectations plus a
// per-cycle comparison against a behavioural model of the controller.
module tb_int_ctrl;

    localparam int NS  = 6;
    localparam int ALL = (1 << NS) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    ADD_I;
    logic          WE_I;
    logic [31:0]   DAT_I;
    logic [31:0]   DAT_O;
    logic [NS-1:0] IRQ_I;
    logic [NS-1:0] IRQ_O;

    int checks   = 0;
    int failures = 0;

    int_ctrl #(.N_SRC(NS)) dut (
        .clk   (clk),
        .reset (reset),
        .ADD_I (ADD_I),
        .WE_I  (WE_I),
        .DAT_I (DAT_I),
        .DAT_O (DAT_O),
        .IRQ_I (IRQ_I),
        .IRQ_O (IRQ_O)
    );

    always #5 clk = ~clk;

    // Model: mode 0 = idle, 1 = asserting, 2 = in service.
    int m_gen, m_rr, m_mask, m_pend, m_prev, m_mode, m_gid, m_ptr;

    task automatic model_step();
        int elig, win, rise, np, reg_sel;
        bit have;
        if (reset) begin
            m_gen = 0; m_rr = 0; m_mask = 0; m_pend = 0;
            m_prev = 0; m_mode = 0; m_gid = 0; m_ptr = 0;
            return;
        end
        reg_sel = int'(ADD_I[3:2]);
        elig = (m_gen != 0) ? (m_pend & m_mask) : 0;
        have = 0;
        win  = 0;
        for (int k = 0; k < NS; k++) begin
            int j;
            j = (m_rr != 0) ? (m_ptr + k) % NS : k;
            if (!have && ((elig >> j) & 1) != 0) begin
                have = 1;
                win  = j;
            end
        end
        rise = int'(IRQ_I) & ~m_prev;
        np = m_pend;
        if (WE_I && reg_sel == 2) np = np & ~int'(DAT_I);
        if (m_mode == 0) begin
            if (have) begin m_mode = 1; m_gid = win; end
        end else if (m_mode == 1) begin
            if (WE_I && reg_sel == 3) begin
                m_mode = 2;
                np = np & ~(1 << m_gid);
            end else if (((elig >> m_gid) & 1) == 0) begin
                m_mode = 0;
            end
        end else begin
            if (WE_I && reg_sel == 3) begin
                m_mode = 0;
                m_ptr  = (m_gid + 1) % NS;
            end
        end
        m_pend = (np | rise) & ALL;
        if (WE_I && reg_sel == 0) begin
            m_gen = int'(DAT_I[0]);
            m_rr  = int'(DAT_I[1]);
        end
        if (WE_I && reg_sel == 1) m_mask = int'(DAT_I) & ALL;
        m_prev = int'(IRQ_I);
    endtask

    function automatic logic [31:0] m_read(input logic [3:0] a);
        case (a[3:2])
            2'd0: return 32'(m_rr * 2 + m_gen);
            2'd1: return 32'(m_mask);
            2'd2: return 32'(m_pend);
            default: return (m_mode == 2 ? 32'h8000_0000 : 32'h0) |
                            (m_mode == 1 ? 32'h4000_0000 : 32'h0) | 32'(m_gid);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        model_step();
    end

    initial forever begin
        @(posedge clk);
        #1;
        chk("model_irq_o", 32'(IRQ_O), (m_mode == 1) ? 32'(1 << m_gid) : 32'h0);
        chk("model_dat_o", DAT_O, m_read(ADD_I));
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        ADD_I = a; DAT_I = d; WE_I = 1'b1;
        step(1);
        WE_I = 1'b0; DAT_I = '0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string name);
        ADD_I = a; WE_I = 1'b0;
        #1;
        chk(name, DAT_O, exp);
    endtask

    task automatic pulse(input logic [NS-1:0] v);
        IRQ_I = v;
        step(1);
        IRQ_I = '0;
    endtask

    task automatic wait_grant(output int gid);
        int n;
        n = 0;
        while (IRQ_O == '0 && n < 8) begin
            step(1);
            n++;
        end
        if (IRQ_O == '0) begin
            checks++;
            failures++;
            $display("FAIL grant_timeout actual=none required=assert within 8 cycles");
        end
        ADD_I = 4'hC;
        #1;
        gid = int'(DAT_O[2:0]);
    endtask

    initial begin
        int gid;
        int exp_rr [4] = '{0, 1, 0, 1};
        reset = 1'b1; ADD_I = '0; WE_I = 1'b0; DAT_I = '0; IRQ_I = '0;
        step(3);
        reset = 1'b0;
        chk("reset_irq_o", 32'(IRQ_O), 32'h0);
        rd(4'h0, 32'h0, "reset_ctrl");
        rd(4'h4, 32'h0, "reset_mask");
        rd(4'h8, 32'h0, "reset_pend");
        rd(4'hC, 32'h0, "reset_claim");

        // Basic flow on source 2.
        wr(4'h4, 32'h3F);
        wr(4'h0, 32'h1);
        IRQ_I = 6'h04;
        step(1);
        rd(4'h8, 32'h04, "edge_pend");
        chk("edge_irq_o_early", 32'(IRQ_O), 32'h0);
        step(1);
        IRQ_I = '0;
        chk("edge_irq_o", 32'(IRQ_O), 32'h04);
        rd(4'hC, 32'h4000_0002, "claim_asserting");
        wr(4'hC, 32'h0);
        chk("claim_irq_o", 32'(IRQ_O), 32'h0);
        rd(4'hC, 32'h8000_0002, "claim_in_service");
        rd(4'h8, 32'h0, "claim_pend_cleared");
        wr(4'hC, 32'h0);
        rd(4'hC, 32'h0000_0002, "eoi_idle");

        // Fixed priority, sources 1 and 4 together.
        pulse(6'h12);
        step(1);
        chk("fixed_first", 32'(IRQ_O), 32'h02);
        wr(4'hC, 32'h0);
        wr(4'hC, 32'h0);
        chk("fixed_gap", 32'(IRQ_O), 32'h0);
        step(1);
        chk("fixed_second", 32'(IRQ_O), 32'h10);
        wr(4'hC, 32'h0);
        wr(4'hC, 32'h0);

        // Round robin versus fixed with sources 0 and 1 re-pulsed in service.
        wr(4'h0, 32'h3);
        pulse(6'h03);
        for (int r = 0; r < 4; r++) begin
            wait_grant(gid);
            chk($sformatf("rr_grant%0d", r), 32'(gid), 32'(exp_rr[r]));
            wr(4'hC, 32'h0);
            pulse(6'h03);
            wr(4'hC, 32'h0);
        end
        wr(4'h0, 32'h1);
        for (int r = 0; r < 3; r++) begin
            wait_grant(gid);
            chk($sformatf("fixed_grant%0d", r), 32'(gid), 32'h0);
            wr(4'hC, 32'h0);
            pulse(6'h03);
            wr(4'hC, 32'h0);
        end
        wr(4'h0, 32'h0);
        wr(4'h8, 32'h3F);
        wr(4'h0, 32'h1);

        // Mask drop while asserting source 3.
        pulse(6'h08);
        step(1);
        chk("mask_assert", 32'(IRQ_O), 32'h08);
        wr(4'h4, 32'h37);
        step(1);
        chk("mask_drop_irq_o", 32'(IRQ_O), 32'h0);
        rd(4'hC, 32'h0000_0003, "mask_drop_idle");
        rd(4'h8, 32'h08, "mask_drop_pend");
        wr(4'h8, 32'h08);
        wr(4'h4, 32'h3F);

        // W1C colliding with a rising edge, then a long-held source.
        IRQ_I = 6'h20;
        wr(4'h8, 32'h20);
        rd(4'h8, 32'h20, "w1c_set_wins");
        step(1);
        chk("held_assert", 32'(IRQ_O), 32'h20);
        wr(4'hC, 32'h0);
        wr(4'hC, 32'h0);
        step(6);
        chk("held_single_irq_o", 32'(IRQ_O), 32'h0);
        rd(4'h8, 32'h0, "held_single_pend");
        rd(4'hC, 32'h0000_0005, "held_single_idle");
        IRQ_I = '0;
        step(1);

        // Asynchronous reset while asserting, then while in service.
        pulse(6'h01);
        step(1);
        chk("pre_reset_irq_o", 32'(IRQ_O), 32'h01);
        #1;
        reset = 1'b1;
        #1;
        chk("async_reset_drop", 32'(IRQ_O), 32'h0);
        step(2);
        reset = 1'b0;
        wr(4'h4, 32'h3F);
        wr(4'h0, 32'h1);
        pulse(6'h01);
        wait_grant(gid);
        wr(4'hC, 32'h0);
        rd(4'hC, 32'h8000_0000, "service_before_reset");
        reset = 1'b1;
        #1;
        chk("service_reset_irq_o", 32'(IRQ_O), 32'h0);
        step(2);
        reset = 1'b0;
        rd(4'h0, 32'h0, "post_reset_ctrl");
        rd(4'h4, 32'h0, "post_reset_mask");
        rd(4'h8, 32'h0, "post_reset_pend");
        rd(4'hC, 32'h0, "post_reset_claim");
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
